// File: rtl/axil_reg_pkg.sv
// Shared types, constants and address decode for the AXI-Lite register bank.
//   resp_t    : AXI response codes
//   w_beat_t  : write-data channel payload (strobe + data)
//   r_beat_t  : read-data channel payload (response + data)
//   dec_t     : decode result {err, idx}
package axil_reg_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    localparam int unsigned ID_IDX    = 0;
    localparam int unsigned CYCLE_IDX = 1;

    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef struct packed {
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } w_beat_t;

    typedef struct packed {
        resp_t             resp;
        logic [DATA_W-1:0] data;
    } r_beat_t;

    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Map a byte address onto a word index inside the window [base, base+4n).
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       n);
        logic [ADDR_W-1:0] off;
        dec_t              d;
        off   = addr - base;
        d.idx = off[ADDR_W-1:2];
        d.err = (addr < base) || (off[1:0] != 2'b00) ||
                ({2'b00, off[ADDR_W-1:2]} >= ADDR_W'(n));
        return d;
    endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI-Lite bundle between the shell OCL port (master) and the register bank (slave).
//   aw*: write address, w*: write data, b*: write response,
//   ar*: read address,  r*: read data.
interface axil_reg_bank_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;

    logic        wvalid;
    logic        wready;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;

    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wstrb, wdata, bready,
               arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wstrb, wdata, bready,
               arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

endinterface

// File: rtl/axil_chan_fifo.sv
// Valid/ready FIFO used to buffer one AXI-Lite channel.
//   clk, rst_n          : clock, async active-low reset
//   in_valid_i/ready_o  : enqueue handshake, in_data_i payload
//   out_valid_o/ready_i : dequeue handshake, out_data_o payload (head entry)
// in_ready_o and out_valid_o are flops loaded from the next-state count, so
// in_ready_o stays low through reset and only rises on the first clock edge.
module axil_chan_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, valid_q;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = in_valid_i && ready_q;
    assign pop  = valid_q && out_ready_i;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= (cnt_d != CNT_W'(DEPTH));
            valid_q  <= (cnt_d != '0);
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axil_reg_bank.sv
// AXI-Lite slave register bank.
//   clk, reset_n : clock, async active-low reset
//   bus          : AXI-Lite slave (AW/W/B/AR/R), every channel queued Q_DEPTH deep
//   vdip         : vdip[0] picks the upper half of the LED register
//   vled         : 16-bit LED view of register LED_REG
// Map: idx 0 ID (RO), idx 1 free-running cycle counter (RO), idx 2.. RW scratch.
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
    parameter int unsigned Q_DEPTH   = 2,
    parameter logic [31:0] ID_VALUE  = 32'hC1A0_0001,
    parameter int unsigned LED_REG   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    axil_reg_bank_if.slave  bus,
    input  logic [15:0]     vdip,
    output logic [15:0]     vled
);

    // Parameter legality.
    if (NUM_REGS < 3 || NUM_REGS > 64) begin : g_bad_num_regs
        $fatal(1, "axil_reg_bank: NUM_REGS must be in 3..64");
    end
    if (LED_REG < 2 || LED_REG >= NUM_REGS) begin : g_bad_led_reg
        $fatal(1, "axil_reg_bank: LED_REG must be in 2..NUM_REGS-1");
    end
    if (Q_DEPTH < 1) begin : g_bad_q_depth
        $fatal(1, "axil_reg_bank: Q_DEPTH must be at least 1");
    end

    localparam int unsigned W_W = $bits(w_beat_t);
    localparam int unsigned R_W = $bits(r_beat_t);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] cycle_q;

    logic              aw_valid, w_valid, ar_valid;
    logic              b_ready, r_ready;
    logic [ADDR_W-1:0] aw_addr, ar_addr;
    w_beat_t           w_in, w_out;
    r_beat_t           r_in, r_out;
    resp_t             wr_resp;
    logic              wr_en;
    logic              wr_fire, rd_fire;
    dec_t              wr_dec, rd_dec;
    logic              unused_vdip;

    assign unused_vdip = ^vdip[15:1];

    // Channel queues.
    axil_chan_fifo #(.WIDTH(ADDR_W), .DEPTH(Q_DEPTH)) u_aw_q (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (bus.awvalid),
        .in_ready_o  (bus.awready),
        .in_data_i   (bus.awaddr),
        .out_valid_o (aw_valid),
        .out_ready_i (wr_fire),
        .out_data_o  (aw_addr)
    );

    assign w_in.strb = bus.wstrb;
    assign w_in.data = bus.wdata;

    axil_chan_fifo #(.WIDTH(W_W), .DEPTH(Q_DEPTH)) u_w_q (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (bus.wvalid),
        .in_ready_o  (bus.wready),
        .in_data_i   (w_in),
        .out_valid_o (w_valid),
        .out_ready_i (wr_fire),
        .out_data_o  (w_out)
    );

    axil_chan_fifo #(.WIDTH(2), .DEPTH(Q_DEPTH)) u_b_q (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (wr_fire),
        .in_ready_o  (b_ready),
        .in_data_i   (wr_resp),
        .out_valid_o (bus.bvalid),
        .out_ready_i (bus.bready),
        .out_data_o  (bus.bresp)
    );

    axil_chan_fifo #(.WIDTH(ADDR_W), .DEPTH(Q_DEPTH)) u_ar_q (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (bus.arvalid),
        .in_ready_o  (bus.arready),
        .in_data_i   (bus.araddr),
        .out_valid_o (ar_valid),
        .out_ready_i (rd_fire),
        .out_data_o  (ar_addr)
    );

    axil_chan_fifo #(.WIDTH(R_W), .DEPTH(Q_DEPTH)) u_r_q (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (rd_fire),
        .in_ready_o  (r_ready),
        .in_data_i   (r_in),
        .out_valid_o (bus.rvalid),
        .out_ready_i (bus.rready),
        .out_data_o  (r_out)
    );

    assign bus.rresp = r_out.resp;
    assign bus.rdata = r_out.data;

    // A write needs a paired AW/W head and room for its response.
    assign wr_fire = aw_valid && w_valid && b_ready;
    assign rd_fire = ar_valid && r_ready;

    // Write decode and byte-strobed register update.
    always_comb begin
        wr_dec  = decode(aw_addr, BASE_ADDR, NUM_REGS);
        wr_resp = OKAY;
        wr_en   = 1'b0;
        if (wr_dec.err) begin
            wr_resp = DECERR;
        end else if (wr_dec.idx == IDX_W'(ID_IDX) || wr_dec.idx == IDX_W'(CYCLE_IDX)) begin
            wr_resp = SLVERR;
        end else begin
            wr_en = 1'b1;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 2; i < NUM_REGS; i++) begin
            if (wr_fire && wr_en && wr_dec.idx == IDX_W'(i)) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_out.strb[b]) regs_d[i][8*b +: 8] = w_out.data[8*b +: 8];
                end
            end
        end
    end

    // Read decode; samples register state ahead of any same-cycle write.
    always_comb begin
        rd_dec    = decode(ar_addr, BASE_ADDR, NUM_REGS);
        r_in.resp = OKAY;
        r_in.data = '0;
        if (rd_dec.err) begin
            r_in.resp = DECERR;
            r_in.data = ERR_RDATA;
        end else if (rd_dec.idx == IDX_W'(ID_IDX)) begin
            r_in.data = ID_VALUE;
        end else if (rd_dec.idx == IDX_W'(CYCLE_IDX)) begin
            r_in.data = cycle_q;
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (rd_dec.idx == IDX_W'(i)) r_in.data = regs_q[i];
            end
        end
    end

    // Register array and free-running cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            cycle_q <= '0;
        end else begin
            regs_q  <= regs_d;
            cycle_q <= cycle_q + DATA_W'(1);
        end
    end

    assign vled = vdip[0] ? regs_q[LED_REG][31:16] : regs_q[LED_REG][15:0];

endmodule

// File: tb/tb_axil_reg_bank.sv
// Scoreboard bench for axil_reg_bank: expected responses are queued when a
// request is issued and compared when the DUT hands a response over.
module tb_axil_reg_bank;

    localparam int unsigned NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_0500;
    localparam logic [31:0] ID   = 32'hC1A0_0001;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        bit          cmp_data;
    } rexp_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] vdip;
    logic [15:0] vled;

    axil_reg_bank_if bus ();

    axil_reg_bank u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .vdip    (vdip),
        .vled    (vled)
    );

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_b [$];
    rexp_t       exp_r [$];
    logic [31:0] cyc_q [$];
    logic [31:0] mdl [NR];
    logic [1:0]  eb;
    rexp_t       er;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        if (a < BASE || a[1:0] != 2'b00 || (a - BASE) >= 32'(4 * NR)) return 2'b11;
        if ((a - BASE) < 32'd8) return 2'b10;
        return 2'b00;
    endfunction

    // Response monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (reset_n && bus.bvalid && bus.bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                eb = exp_b.pop_front();
                chk("bresp", bus.bresp, eb);
            end
        end
        if (reset_n && bus.rvalid && bus.rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                er = exp_r.pop_front();
                chk("rresp", bus.rresp, er.resp);
                if (er.cmp_data) chk("rdata", bus.rdata, er.data);
                else cyc_q.push_back(bus.rdata);
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        bit ok = 1'b0;
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.awready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        if (!ok) chk("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        bus.wvalid = 1'b1;
        bus.wdata  = d;
        bus.wstrb  = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        if (!ok) chk("w_timeout", 0, 1);
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        if (!ok) chk("ar_timeout", 0, 1);
    endtask

    // Queue the expected response and apply the write to the model.
    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        int         k;
        r = resp_of(a);
        exp_b.push_back(r);
        if (r == 2'b00) begin
            k = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++) if (s[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        expect_wr(a, d, s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic rd(input logic [31:0] a);
        rexp_t e;
        int    k;
        if (resp_of(a) == 2'b11) begin
            e.resp = 2'b11; e.data = 32'hDEAD_BEEF; e.cmp_data = 1'b1;
        end else begin
            k = int'((a - BASE) >> 2);
            e.resp = 2'b00;
            e.cmp_data = (k != 1);
            e.data = (k == 0) ? ID : (k == 1) ? 32'h0 : mdl[k];
        end
        exp_r.push_back(e);
        send_ar(a);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_b", exp_b.size(), 0);
        chk("drain_r", exp_r.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        vdip    = 16'h0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.bready  = 1'b1; bus.rready = 1'b1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        // Reset state and ready release timing
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_awready", bus.awready, 0);
        chk("rst_vled", vled, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("awready_pre_edge", bus.awready, 0);
        @(posedge clk); #1;
        chk("awready_post_edge", bus.awready, 1);
        chk("arready_post_edge", bus.arready, 1);

        // 1: full write/read and LED halves
        wr(BASE + 32'd8, 32'h1234_5678, 4'hF);
        drain();
        rd(BASE + 32'd8);
        drain();
        vdip = 16'h0000; #1;
        chk("vled_lo", vled, 16'h5678);
        vdip = 16'h0001; #1;
        chk("vled_hi", vled, 16'h1234);
        vdip = 16'h0000;

        // 2: byte strobes
        wr(BASE + 32'd8, 32'hAABB_CCDD, 4'b0101);
        drain();
        rd(BASE + 32'd8);
        wr(BASE + 32'd12, 32'hFFFF_FFFF, 4'h0);
        drain();
        rd(BASE + 32'd12);
        drain();

        // 3: ID, write to RO, cycle counter delta
        rd(BASE);
        wr(BASE + 32'd4, 32'h0BAD_0BAD, 4'hF);
        drain();
        rd(BASE + 32'd4);
        repeat (4) begin @(posedge clk); #1; end
        rd(BASE + 32'd4);
        drain();
        chk("cycle_reads", cyc_q.size(), 2);
        if (cyc_q.size() == 2) chk("cycle_delta", cyc_q[1] - cyc_q[0], 5);

        // 4: decode errors leave registers untouched
        rd(BASE + 32'(4 * NR));
        rd(BASE + 32'd2);
        wr(BASE - 32'd4, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'd9, 32'hFFFF_FFFF, 4'hF);
        drain();
        for (int i = 2; i < NR; i++) rd(BASE + 32'(4 * i));
        drain();

        // 5: W ahead of AW, response latency, backpressure and ordering
        bus.bready = 1'b0;
        expect_wr(BASE + 32'd12, 32'h1111_1111, 4'hF);
        send_w(32'h1111_1111, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        bus.awvalid = 1'b1;
        bus.awaddr  = BASE + 32'd12;
        @(negedge clk);
        chk("aw_ready_lat", bus.awready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        chk("b_lat_1", bus.bvalid, 0);
        @(posedge clk); #1;
        chk("b_lat_2", bus.bvalid, 1);
        wr(BASE + 32'd16, 32'h2222_2222, 4'hF);
        wr(BASE + 32'd20, 32'h3333_3333, 4'hF);
        wr(BASE + 32'd12, 32'h4444_4444, 4'hF);
        repeat (3) begin @(posedge clk); #1; end
        chk("aw_full", bus.awready, 0);
        chk("w_full", bus.wready, 0);
        chk("b_hold_valid", bus.bvalid, 1);
        chk("b_hold_resp", bus.bresp, 0);
        bus.bready = 1'b1;
        drain();
        rd(BASE + 32'd12);
        rd(BASE + 32'd16);
        rd(BASE + 32'd20);
        drain();

        // 6: reset in the middle of traffic
        bus.bready = 1'b0;
        wr(BASE + 32'd8, 32'hCAFE_F00D, 4'hF);
        repeat (3) begin @(posedge clk); #1; end
        send_aw(BASE + 32'd12);
        @(posedge clk); #1;
        chk("pre_rst_bvalid", bus.bvalid, 1);
        chk("pre_rst_vled", vled, 16'hF00D);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", bus.bvalid, 0);
        chk("mid_rst_vled", vled, 0);
        chk("mid_rst_awready", bus.awready, 0);
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.bready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_b", bus.bvalid, 0);
        for (int i = 2; i < 5; i++) rd(BASE + 32'(4 * i));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- Parametrised AXI-Lite slave register bank: generalises the single hello-world register to NUM_REGS word registers behind a decoded address window.
- Adds byte-strobe writes, a read-only ID register, a free-running cycle counter, SLVERR/DECERR responses and DIP-selected LED output.
- Sits between the shell's AXI-Lite OCL port and custom-logic status/control.
- Every AXI channel is buffered by a Q_DEPTH-entry queue.

Parameters:
- NUM_REGS, 8, total word registers (min 3, max 64).
- BASE_ADDR, 32'h0000_0500, byte address of register 0 (aligned to 4*NUM_REGS rounded up to a power of 2).
- Q_DEPTH, 2, entries per channel queue (min 1).
- ID_VALUE, 32'hC1A0_0001, value returned by register 0.
- LED_REG, 2, index of the register driven to vled (2..NUM_REGS-1).

Ports:
- clk in 1: sole clock.
- reset_n in 1: asynchronous, active-low reset.
- awvalid in 1, awready out 1, awaddr in 32: write address channel.
- wvalid in 1, wready out 1, wstrb in 4, wdata in 32: write data channel.
- bvalid out 1, bready in 1, bresp out 2: write response channel.
- arvalid in 1, arready out 1, araddr in 32: read address channel.
- rvalid out 1, rready in 1, rresp out 2, rdata out 32: read data channel.
- vdip in 16: vdip[0] selects the upper LED half.
- vled out 16: LED output.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All queues empty; bvalid=rvalid=0.
  - All RW registers 0; cycle counter 0; vled=0.
  - awready, wready and arready may not rise before the first clk edge after reset_n deasserts.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[31:2].
  - DECERR (2'b11) if addr < BASE_ADDR, off[1:0] != 0, or idx >= NUM_REGS.
- Register map:
  - idx 0: ID, RO.
  - idx 1: CYCLE, RO, 32-bit, +1 every clk, wraps 32'hFFFF_FFFF -> 0.
  - idx 2..NUM_REGS-1: RW scratch.
- Write transaction:
  - Fires when waddr and wdata queues are both non-empty and the bresp queue is non-full.
  - Dequeues both queues, enqueues one response, all in that same cycle.
  - RW target: byte i is updated iff wstrb[i]; bresp=OKAY (2'b00). wstrb=0 gives OKAY with no change.
  - RO target: SLVERR (2'b10), no state change.
  - Out of range: DECERR, no state change.
  - AW and W may arrive in any order or cycle; pairing is strictly FIFO.
- Read transaction:
  - Fires when the raddr queue is non-empty and the rresp queue is non-full.
  - Response data is the register value at the firing cycle, before any same-cycle write.
  - Error responses return rdata=32'hDEAD_BEEF with the matching rresp.
- Latency: with empty queues and ready sinks, bvalid/rvalid assert 2 cycles after the last input handshake (1 cycle queue, 1 cycle response queue).
- Independence: read and write transactions can fire in the same cycle; they are independent paths with no ordering between them.
- Backpressure:
  - bready=0 holds bvalid, bresp stable; with the bresp queue full, writes stall and AW/W fill to Q_DEPTH, then awready/wready drop.
  - Same rule for the read side.
- vled: vdip[0] ? reg[LED_REG][31:16] : reg[LED_REG][15:0]. Combinational from the register, so it updates the cycle after the write fires.
- Elaboration check: illegal parameters (NUM_REGS<3, LED_REG out of range, Q_DEPTH<1) trigger $fatal.

Decomposition:
- Package axil_reg_pkg holds:
  - resp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - ERR_RDATA = 32'hDEAD_BEEF.
  - ID_IDX = 0, CYCLE_IDX = 1.
  - Function decode(addr, base, n) returning {err, idx}.
- One sub-module, axil_chan_fifo: parametrised width/depth valid-ready FIFO with async active-low reset, instantiated five times.
- Register array, counter and decode stay in the top level.

Test Plan:
1. Reset, then write 32'h1234_5678 wstrb=4'hF to BASE+8 and read BASE+8 -> bresp=0; rresp=0, rdata=32'h1234_5678; vdip[0]=0 gives vled=16'h5678, vdip[0]=1 gives 16'h1234.
2. Reg2=32'h1234_5678, write 32'hAABB_CCDD wstrb=4'b0101 -> read gives 32'h12BB_56DD.
3. Read BASE+0 -> 32'hC1A0_0001. Write to BASE+4 -> bresp=2'b10. Two CYCLE reads k cycles apart differ by k.
4. Read BASE+4*NUM_REGS, read BASE+2, write BASE-4 -> resp 2'b11, rdata 32'hDEAD_BEEF, no register changes.
5. W data 3 cycles before AW, then hold bready=0 while issuing 4 writes:
   - First: bvalid 2 cycles after AW.
   - With Q_DEPTH=2, awready drops after the queues fill; on release, 4 OKAY responses in order.
6. Assert reset_n=0 mid-transfer with bvalid=1 and queues partly full -> immediately bvalid=0, registers 0, no stale response after release.
